// File: rtl/ca_pipe_pkg.sv
// Shared pipeline definitions: operand-select encodings, register address width
// and the per-stage tag records carried alongside instructions.
package ca_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_EX  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Tag held in MEM and WB: only what is needed to decide a forward.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  valid;
    } stage_tag_t;

    // Tag held in EX: also carries sources and the load flag for hazard checks.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  valid;
    } ex_tag_t;

    // A stage can supply a source when it really writes a non-x0 register of that number.
    function automatic logic tag_hits(input stage_tag_t t, input logic [REG_ADDR_W-1:0] src);
        return t.valid && t.regwrite && (t.rd != '0) && (t.rd == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand bypass select for one EX source: MEM result beats WB data, else register file.
module fwd_select
    import ca_pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  stage_tag_t            mem_tag,
    input  stage_tag_t            wb_tag,
    output logic [1:0]            sel
);

    always_comb begin
        sel = FWD_EX;
        if (tag_hits(mem_tag, src)) begin
            sel = FWD_MEM;
        end else if (tag_hits(wb_tag, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and load-use stall control for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add the saturating stall-cycle counter output.
module hazard_forward_ctrl
    import ca_pipe_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  id_valid_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  stall_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    ex_tag_t    ex_q;
    ex_tag_t    ex_d;
    stage_tag_t mem_q;
    stage_tag_t wb_q;

    // Load in EX whose result the ID instruction needs before it exists.
    always_comb begin
        stall_o = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid_i &&
                  ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
    end

    // Stalled, flushed and invalid ID instructions all enter EX as a fully cleared bubble.
    always_comb begin
        ex_d = '0;
        if (id_valid_i && !flush_i && !stall_o) begin
            ex_d.rs1      = id_rs1_i;
            ex_d.rs2      = id_rs2_i;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
            ex_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{rd: ex_q.rd, regwrite: ex_q.regwrite, valid: ex_q.valid};
            wb_q  <= mem_q;
        end
    end

    fwd_select u_fwd_a (
        .src     (ex_q.rs1),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (fwd_a_o)
    );

    fwd_select u_fwd_b (
        .src     (ex_q.rs2),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (fwd_b_o)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Counts every stalled edge, including ones where a flush also squashes ID.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports id_rs1_i and id_rs2_i, input, 5 bits each: source register numbers of the instruction in ID.
REQ-004 SHALL have port id_rd_i, input, 5 bits: destination register number of the instruction in ID.
REQ-005 SHALL have ports id_regwrite_i, id_memread_i and id_valid_i, input, 1 bit each: ID-stage control bits.
REQ-006 SHALL have port flush_i, input, 1 bit: squash the ID instruction (taken branch).
REQ-007 SHALL have ports fwd_a_o and fwd_b_o, output, 2 bits each: operand select for the EX operand mux; 00 = EX register data, 10 = MEM ALU result, 01 = WB write data.
REQ-008 SHALL have port stall_o, output, 1 bit: load-use stall request to the PC and IF/ID registers.
REQ-009 SHALL have port stall_cnt_o, output, 32 bits: stall-cycle counter, present only under HAZARD_PERF_CNT_EN.

Function
REQ-010 SHALL hold an internal tag pipeline of three stages:
- EX: rs1, rs2, rd, regwrite, memread, valid.
- MEM: rd, regwrite, valid.
- WB: rd, regwrite, valid.
REQ-011 SHALL advance every cycle: ID->EX, EX->MEM, MEM->WB; the WB tag is discarded.
REQ-012 SHALL compute fwd_a_o combinationally from EX.rs1 (fwd_b_o from EX.rs2). A stage matches when it is valid, its regwrite is 1, its rd is nonzero and its rd equals the source.
- MEM match -> 10.
- Otherwise WB match -> 01.
- Otherwise -> 00.
REQ-013 SHALL give MEM priority over WB when both stages match the same source.
REQ-014 SHALL never forward for source x0; fwd is 00 whenever the source is 0.
REQ-015 SHALL assert stall_o combinationally when all of the following hold:
- EX.valid, EX.memread and EX.rd != 0;
- EX.rd equals id_rs1_i or id_rs2_i;
- id_valid_i is 1.
REQ-016 SHALL load a bubble (all valid bits 0) into EX on the clock edge where stall_o is 1; MEM and WB still advance.
REQ-017 SHALL load a bubble into EX when flush_i is 1, regardless of stall_o.
REQ-018 SHALL give flush_i priority when flush_i and stall_o are 1 in the same cycle: EX gets a bubble and the stall counter still increments.
REQ-019 SHALL release stall after one cycle for a single load-use: once the bubble is in EX, the load is in MEM, so stall_o falls and the dependent instruction later forwards from WB (01).
REQ-020 SHALL treat an ID instruction with id_valid_i=0 as a bubble.

Reset
REQ-021 SHALL clear every EX/MEM/WB valid, regwrite, memread and register field to 0 while rst_i is high.
REQ-022 SHALL therefore drive fwd_a_o=00, fwd_b_o=00 and stall_o=0 during reset; stall_cnt_o SHALL be 0.
REQ-023 SHALL discard all in-flight tags when reset asserts mid-operation; the first post-reset instruction sees no forwarding.

Configuration
REQ-024 SHALL use macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt_o exists and increments by 1 on every clock edge where stall_o is 1, saturating at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Structure
REQ-025 SHALL take the following from shared package ca_pipe_pkg:
- select encodings FWD_EX=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01;
- REG_ADDR_W=5;
- a stage-tag struct type.
REQ-026 SHALL use one sub-module, fwd_select: combinational source-vs-MEM/WB compare and priority encode, instanced twice (operands A and B).

Verification
REQ-027 SHALL be tested with these directed scenarios:
- EX-to-EX: add x5 then sub x6,x5,x1 -> next cycle fwd_a_o=10, fwd_b_o=00.
- Distance 2: add x5, nop, or x7,x1,x5 -> fwd_b_o=01.
- Double hit: add x5 twice consecutively, then and x8,x5,x5 -> fwd_a_o=fwd_b_o=10 (MEM wins).
- x0 write: addi x0 then add x9,x0,x0 -> fwd 00/00.
- Load-use: lw x4 then add x3,x4,x2 -> stall_o=1 for exactly 1 cycle, then fwd_a_o=01; stall_cnt_o=1.
- Flush and stall together: flush_i=1 in the stall cycle -> EX bubble, no forward to the squashed instruction; rst_i pulse mid-stream -> all outputs 0 in the same cycle.
